// File: rtl/test_m_pkg.sv
// Shared constants and the truth-table lookup for test_m.
package test_m_pkg;

  localparam logic [7:0]  TT_DEFAULT            = 8'h96;
  localparam int unsigned STABLE_CYCLES_DEFAULT = 2;
  localparam int unsigned STABLE_CYCLES_MAX     = 16;
  localparam int unsigned CNT_W                 = 4;
  localparam int unsigned CODE_W                = 3;

  function automatic logic tt_lookup(input logic [7:0] tt, input logic [CODE_W-1:0] code);
    return tt[code];
  endfunction

endpackage

// File: rtl/test_m_filter.sv
// Debounce filter: F follows the registered decoded value only after it
// has disagreed with F for STABLE_CYCLES consecutive cycles.
module test_m_filter
  import test_m_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_c,
  output logic f
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             raw_q, raw_d;
  logic             f_q, f_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive disagreements; commit on the last one, clear on agreement.
  always_comb begin
    raw_d = raw_c;
    f_d   = f_q;
    cnt_d = '0;
    if (raw_q != f_q) begin
      if (cnt_q >= CNT_LAST) begin
        f_d   = raw_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q <= 1'b0;
      f_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      raw_q <= raw_d;
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  assign f = f_q;

endmodule

// File: rtl/test_m.sv
// Thin top: truth-table decode of A feeding the stability filter.
module test_m
  import test_m_pkg::*;
#(
  parameter logic [7:0]  TRUTH_TABLE   = TT_DEFAULT,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] A,
  output logic              F
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > STABLE_CYCLES_MAX) begin : g_bad_stable_cycles
    $error("test_m: STABLE_CYCLES out of range 1..16");
  end

  logic raw_c;

  assign raw_c = tt_lookup(TRUTH_TABLE, A);

  test_m_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk  (clk),
    .rst  (rst),
    .raw_c(raw_c),
    .f    (F)
  );

endmodule

// File: tb/tb_test_m.sv
// Bench for test_m: default instance plus a majority/STABLE_CYCLES=1 instance,
// checked against a sliding-window model of the decoded sample history.
module tb_test_m;

  localparam int unsigned S_A  = 2;
  localparam logic [7:0]  TT_A = 8'h96;
  localparam int unsigned S_B  = 1;
  localparam logic [7:0]  TT_B = 8'hE8;

  logic       clk;
  logic       rst;
  logic [2:0] a_a, a_b;
  logic       f_a, f_b;

  int total = 0;
  int bad   = 0;

  // model state: current F, history of decoded samples since last F change
  logic        mf_a, mf_b;
  logic [31:0] hist_a, hist_b;
  int          hlen_a, hlen_b;

  test_m #(.TRUTH_TABLE(TT_A), .STABLE_CYCLES(S_A)) dut (
    .clk(clk), .rst(rst), .A(a_a), .F(f_a)
  );

  test_m #(.TRUTH_TABLE(TT_B), .STABLE_CYCLES(S_B)) dut_maj (
    .clk(clk), .rst(rst), .A(a_b), .F(f_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // F changes when the last S samples since the previous change all disagree with F.
  task automatic model_edge(input int unsigned s, input logic [7:0] tt, input logic [2:0] a,
                            inout logic f, inout logic [31:0] hist, inout int hlen);
    logic flip;
    flip = (hlen >= int'(s));
    for (int i = 0; i < int'(s); i++)
      if (hist[i] == f) flip = 1'b0;
    if (flip) begin
      f    = ~f;
      hist = '0;
      hlen = 0;
    end
    hist = {hist[30:0], tt[a]};
    if (hlen < 32) hlen++;
  endtask

  // Expected counter: trailing disagreeing samples already examined by an edge.
  function automatic int model_cnt(input logic f, input logic [31:0] hist, input int hlen);
    int n = 0;
    for (int i = 1; i < hlen; i++) begin
      if (hist[i] == f) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    mf_a = 1'b0; hist_a = '0; hlen_a = 1;
    mf_b = 1'b0; hist_b = '0; hlen_b = 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".f_a"}, int'(f_a), int'(mf_a));
    chk({tag, ".cnt_a"}, int'(dut.u_filter.cnt_q), model_cnt(mf_a, hist_a, hlen_a));
    chk({tag, ".f_b"}, int'(f_b), int'(mf_b));
    chk({tag, ".cnt_b"}, int'(dut_maj.u_filter.cnt_q), model_cnt(mf_b, hist_b, hlen_b));
    chk({tag, ".cnt_a_bound"}, int'(dut.u_filter.cnt_q <= 4'(S_A - 1)), 1);
  endtask

  // Called at posedge+1; drives inputs, takes one edge, checks at posedge+1.
  task automatic step(input string tag, input logic [2:0] a, input logic [2:0] b);
    a_a = a;
    a_b = b;
    @(posedge clk);
    if (!rst) begin
      model_edge(S_A, TT_A, a_a, mf_a, hist_a, hlen_a);
      model_edge(S_B, TT_B, a_b, mf_b, hist_b, hlen_b);
    end
    #1;
    check_all(tag);
  endtask

  // Async reset pulse placed between edges, held across one edge.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk({tag, ".async_f_a"}, int'(f_a), 0);
    chk({tag, ".async_f_b"}, int'(f_b), 0);
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_a = 3'b000;
    a_b = 3'b000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset_f", int'(f_a), 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step("hold0", 3'b000, 3'b000);
      chk("hold0_f", int'(f_a), 0);
      chk("hold0_cnt", int'(dut.u_filter.cnt_q), 0);
    end

    step("rise1", 3'b001, 3'b000); chk("rise_e1", int'(f_a), 0);
    step("rise2", 3'b001, 3'b000); chk("rise_e2", int'(f_a), 0);
    step("rise3", 3'b001, 3'b000); chk("rise_e3", int'(f_a), 1);

    for (int i = 0; i < 4; i++) begin
      step("samedec", 3'b010, 3'b000);
      chk("samedec_f", int'(f_a), 1);
      chk("samedec_cnt", int'(dut.u_filter.cnt_q), 0);
    end

    for (int i = 0; i < 3; i++) step("back0", 3'b000, 3'b000);
    chk("back0_f", int'(f_a), 0);
    step("glitch", 3'b001, 3'b000);
    for (int i = 0; i < 4; i++) begin
      step("glitch_ret", 3'b000, 3'b000);
      chk("glitch_f", int'(f_a), 0);
    end

    step("rst_mid_e1", 3'b011, 3'b000);
    pulse_reset("rst_mid");
    for (int i = 0; i < 3; i++) begin
      step("after_rst", 3'b011, 3'b000);
      chk("after_rst_f", int'(f_a), 0);
    end

    step("maj110_e1", 3'b000, 3'b110); chk("maj110_e1", int'(f_b), 0);
    step("maj110_e2", 3'b000, 3'b110); chk("maj110_e2", int'(f_b), 1);
    step("maj100_e1", 3'b000, 3'b100); chk("maj100_e1", int'(f_b), 1);
    step("maj100_e2", 3'b000, 3'b100); chk("maj100_e2", int'(f_b), 0);

    for (int n = 0; n < 150; n++) begin
      logic [2:0] ra, rb;
      int hold;
      ra   = 3'($urandom_range(0, 7));
      rb   = 3'($urandom_range(0, 7));
      hold = int'($urandom_range(1, 4));
      for (int k = 0; k < hold; k++) begin
        if (($urandom % 8) == 0) rb = 3'($urandom_range(0, 7));
        step("rand", ra, rb);
      end
      if (($urandom % 40) == 0) pulse_reset("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
